// File: rtl/clint_timer_pkg.sv
// Shared constants and state encoding for the core-local timer (CLINT).
package clint_timer_pkg;

  localparam int          CLINT_XLEN          = 64;
  localparam int          CLINT_STRB_W        = CLINT_XLEN / 8;

  // Default byte addresses of the two memory-mapped timer registers.
  localparam logic [63:0] CLINT_MTIME_ADDR    = 64'h0000_0000_0200_BFF8;
  localparam logic [63:0] CLINT_MTIMECMP_ADDR = 64'h0000_0000_0200_4000;

  // mtimecmp comes out of reset at the maximum so no interrupt fires early.
  localparam logic [63:0] CLINT_MTIMECMP_RST  = 64'hFFFF_FFFF_FFFF_FFFF;

  // Interrupt request state machine encoding.
  typedef enum logic {
    CLINT_IDLE = 1'b0,
    CLINT_PEND = 1'b1
  } clint_state_e;

endpackage

// File: rtl/clint_tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV clocks (TICK_DIV = 1..255).
module clint_tick_gen #(
  parameter int TICK_DIV = 1
) (
  input  logic cpu_clk_50M,
  input  logic cpu_rst_n,
  output logic tick
);

  logic [7:0] count;

  assign tick = (count == 8'(TICK_DIV - 1));

  // Count 0..TICK_DIV-1 and wrap back to zero on the tick cycle.
  always_ff @(posedge cpu_clk_50M) begin
    if (!cpu_rst_n) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/clint_timer.sv
// Core-local timer: mtime counter, mtimecmp compare register, a single-beat
// memory-mapped access port and the level-held timer interrupt request.
module clint_timer
  import clint_timer_pkg::*;
#(
  parameter int          TICK_DIV      = 1,
  parameter logic [63:0] MTIMECMP_ADDR = CLINT_MTIMECMP_ADDR,
  parameter logic [63:0] MTIME_ADDR    = CLINT_MTIME_ADDR
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst_n,
  input  logic        clint_ce,
  input  logic        clint_we,
  input  logic [63:0] clint_addr,
  input  logic [63:0] clint_wdata,
  input  logic [7:0]  clint_wstrb,
  output logic        clint_hit,
  output logic [63:0] clint_rdata,
  output logic        clint_rvalid,
  output logic        clock_interr,
  input  logic        interr_isdone,
  output logic        mtip
);

  logic [63:0]  mtime;
  logic [63:0]  mtimecmp;
  logic         tick;
  logic         armed;
  clint_state_e state;

  logic         sel_mtime;
  logic         sel_mtimecmp;
  logic         rd_en;
  logic         wr_mtime;
  logic         wr_mtimecmp;
  logic         unused_addr_bits;

  // Replace only the byte lanes enabled by the strobe, keep the rest.
  function automatic logic [63:0] strb_merge(input logic [63:0] old_val,
                                             input logic [63:0] new_val,
                                             input logic [7:0]  strb);
    logic [63:0] merged;
    merged = old_val;
    for (int i = 0; i < CLINT_STRB_W; i++) begin
      if (strb[i]) begin
        merged[8*i +: 8] = new_val[8*i +: 8];
      end
    end
    return merged;
  endfunction

  clint_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .cpu_clk_50M (cpu_clk_50M),
    .cpu_rst_n   (cpu_rst_n),
    .tick        (tick)
  );

  // Registers are 8-byte aligned, so the low address bits carry no information.
  assign unused_addr_bits = ^clint_addr[2:0];

  assign sel_mtime    = (clint_addr[63:3] == MTIME_ADDR[63:3]);
  assign sel_mtimecmp = (clint_addr[63:3] == MTIMECMP_ADDR[63:3]);
  assign clint_hit    = sel_mtime | sel_mtimecmp;

  assign rd_en        = clint_ce & clint_hit & ~clint_we;
  assign wr_mtime     = clint_ce & clint_we & sel_mtime;
  assign wr_mtimecmp  = clint_ce & clint_we & sel_mtimecmp;

  assign mtip         = (mtime >= mtimecmp);

  // mtime advances on tick; a port write wins and merges into the old value.
  always_ff @(posedge cpu_clk_50M) begin
    if (!cpu_rst_n) begin
      mtime <= '0;
    end else if (wr_mtime) begin
      mtime <= strb_merge(mtime, clint_wdata, clint_wstrb);
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  // mtimecmp changes only through the access port.
  always_ff @(posedge cpu_clk_50M) begin
    if (!cpu_rst_n) begin
      mtimecmp <= CLINT_MTIMECMP_RST;
    end else if (wr_mtimecmp) begin
      mtimecmp <= strb_merge(mtimecmp, clint_wdata, clint_wstrb);
    end
  end

  // Read port returns the pre-edge register value one cycle after the request.
  always_ff @(posedge cpu_clk_50M) begin
    if (!cpu_rst_n) begin
      clint_rdata  <= '0;
      clint_rvalid <= 1'b0;
    end else begin
      clint_rvalid <= rd_en;
      if (rd_en) begin
        clint_rdata <= sel_mtime ? mtime : mtimecmp;
      end
    end
  end

  // Interrupt FSM; armed blocks re-triggering until mtimecmp is rewritten.
  always_ff @(posedge cpu_clk_50M) begin
    if (!cpu_rst_n) begin
      state        <= CLINT_IDLE;
      armed        <= 1'b1;
      clock_interr <= 1'b0;
    end else begin
      case (state)
        CLINT_IDLE: begin
          if (mtip && armed) begin
            state        <= CLINT_PEND;
            clock_interr <= 1'b1;
          end
          if (wr_mtimecmp) begin
            armed <= 1'b1;
          end
        end
        CLINT_PEND: begin
          if (interr_isdone) begin
            state        <= CLINT_IDLE;
            clock_interr <= 1'b0;
            armed        <= wr_mtimecmp;
          end else if (wr_mtimecmp) begin
            armed <= 1'b1;
          end
        end
        default: begin
          state        <= CLINT_IDLE;
          clock_interr <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clint_timer.sv
// Self-checking bench for clint_timer: directed scenarios plus random traffic,
// compared every cycle against a behavioural model of the timer registers.
module tb_clint_timer;

  localparam logic [63:0] MTIME_A = 64'h0000_0000_0200_BFF8;
  localparam logic [63:0] CMP_A   = 64'h0000_0000_0200_4000;
  localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        cpu_clk_50M;
  logic        cpu_rst_n;
  logic        clint_ce;
  logic        clint_we;
  logic [63:0] clint_addr;
  logic [63:0] clint_wdata;
  logic [7:0]  clint_wstrb;
  logic        clint_hit;
  logic [63:0] clint_rdata;
  logic        clint_rvalid;
  logic        clock_interr;
  logic        interr_isdone;
  logic        mtip;

  logic        rst_n_4;
  logic        ce_4;
  logic        we_4;
  logic [63:0] addr_4;
  logic [63:0] wdata_4;
  logic [7:0]  wstrb_4;
  logic        hit_4;
  logic [63:0] rdata_4;
  logic        rvalid_4;
  logic        irq_4;
  logic        isdone_4;
  logic        mtip_4;

  int n_checks;
  int n_fails;

  // Behavioural model of the TICK_DIV=1 instance.
  logic [63:0] m_mtime;
  logic [63:0] m_cmp;
  logic        m_armed;
  logic        m_pend;
  logic [63:0] m_rdata;
  logic        m_rvalid;
  // Edges seen by the TICK_DIV=4 instance since its reset.
  int          e4;

  logic [63:0] mtime_a;
  logic [63:0] cmp_a;

  clint_timer #(.TICK_DIV(1)) dut (
    .cpu_clk_50M   (cpu_clk_50M),
    .cpu_rst_n     (cpu_rst_n),
    .clint_ce      (clint_ce),
    .clint_we      (clint_we),
    .clint_addr    (clint_addr),
    .clint_wdata   (clint_wdata),
    .clint_wstrb   (clint_wstrb),
    .clint_hit     (clint_hit),
    .clint_rdata   (clint_rdata),
    .clint_rvalid  (clint_rvalid),
    .clock_interr  (clock_interr),
    .interr_isdone (interr_isdone),
    .mtip          (mtip)
  );

  clint_timer #(.TICK_DIV(4)) dut4 (
    .cpu_clk_50M   (cpu_clk_50M),
    .cpu_rst_n     (rst_n_4),
    .clint_ce      (ce_4),
    .clint_we      (we_4),
    .clint_addr    (addr_4),
    .clint_wdata   (wdata_4),
    .clint_wstrb   (wstrb_4),
    .clint_hit     (hit_4),
    .clint_rdata   (rdata_4),
    .clint_rvalid  (rvalid_4),
    .clock_interr  (irq_4),
    .interr_isdone (isdone_4),
    .mtip          (mtip_4)
  );

  // Free-running 50 MHz-style clock.
  initial begin
    cpu_clk_50M = 1'b0;
    forever #5 cpu_clk_50M = ~cpu_clk_50M;
  end

  // Expand a byte strobe into a bit mask.
  function automatic logic [63:0] lane_mask(input logic [7:0] strb);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      if (strb[i]) m = m | (64'hFF << (8 * i));
    end
    return m;
  endfunction

  // One comparison: count it, and report it if it disagrees.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle on the main instance, advance the model, check all outputs.
  task automatic applyStimulus(input logic ce, input logic we, input logic [63:0] addr,
                               input logic [63:0] wdata, input logic [7:0] strb,
                               input logic done);
    logic        is_t, is_c, hit, rd, wr_t, wr_c, now_mtip;
    logic [63:0] mask;
    logic [63:0] n_mtime, n_cmp, n_rdata;
    logic        n_armed, n_pend, n_rvalid;
    int          n_e4;
    clint_ce      = ce;
    clint_we      = we;
    clint_addr    = addr;
    clint_wdata   = wdata;
    clint_wstrb   = strb;
    interr_isdone = done;
    #1;
    is_t = ((addr >> 3) == (mtime_a >> 3));
    is_c = ((addr >> 3) == (cmp_a >> 3));
    hit  = is_t || is_c;
    checkOutput("hit", 64'(clint_hit), 64'(hit));

    rd       = ce && hit && !we;
    wr_t     = ce && we && is_t;
    wr_c     = ce && we && is_c;
    mask     = lane_mask(strb);
    now_mtip = (m_mtime >= m_cmp);
    if (!cpu_rst_n) begin
      n_mtime  = 64'd0;
      n_cmp    = ALL_ONES;
      n_armed  = 1'b1;
      n_pend   = 1'b0;
      n_rdata  = 64'd0;
      n_rvalid = 1'b0;
    end else begin
      n_mtime  = wr_t ? ((m_mtime & ~mask) | (wdata & mask)) : m_mtime + 64'd1;
      n_cmp    = wr_c ? ((m_cmp & ~mask) | (wdata & mask)) : m_cmp;
      n_rvalid = rd;
      n_rdata  = rd ? (is_t ? m_mtime : m_cmp) : m_rdata;
      if (m_pend && done) begin
        n_pend  = 1'b0;
        n_armed = wr_c;
      end else begin
        n_pend  = m_pend || (now_mtip && m_armed);
        n_armed = m_armed || wr_c;
      end
    end
    n_e4 = rst_n_4 ? e4 + 1 : 0;

    @(posedge cpu_clk_50M);
    #1;
    m_mtime  = n_mtime;
    m_cmp    = n_cmp;
    m_armed  = n_armed;
    m_pend   = n_pend;
    m_rdata  = n_rdata;
    m_rvalid = n_rvalid;
    e4       = n_e4;
    checkOutput("rvalid", 64'(clint_rvalid), 64'(m_rvalid));
    checkOutput("rdata", clint_rdata, m_rdata);
    checkOutput("clock_interr", 64'(clock_interr), 64'(m_pend));
    checkOutput("mtip", 64'(mtip), 64'(m_mtime >= m_cmp));
  endtask

  // Directed scenarios, random traffic, then the divided-tick instance.
  initial begin
    logic [63:0] exp4;
    logic [63:0] rnd_addr;
    logic        rnd_ce, rnd_we, rnd_done;
    int          pick;

    n_checks = 0;
    n_fails  = 0;
    mtime_a  = MTIME_A;
    cmp_a    = CMP_A;
    m_mtime  = '0;
    m_cmp    = ALL_ONES;
    m_armed  = 1'b1;
    m_pend   = 1'b0;
    m_rdata  = '0;
    m_rvalid = 1'b0;
    e4       = 0;
    cpu_rst_n = 1'b0;
    rst_n_4   = 1'b0;
    ce_4 = 1'b0; we_4 = 1'b0; addr_4 = '0; wdata_4 = '0; wstrb_4 = '0; isdone_4 = 1'b0;

    // Reset for two cycles.
    applyStimulus(0, 0, 64'd0, 64'd0, 8'h00, 0);
    applyStimulus(0, 0, 64'd0, 64'd0, 8'h00, 0);
    checkOutput("reset_interr", 64'(clock_interr), 64'd0);
    checkOutput("reset_rdata", clint_rdata, 64'd0);
    cpu_rst_n = 1'b1;

    // Ten idle cycles, then read mtime.
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 64'd0, 64'd0, 8'h00, 0);
    applyStimulus(1, 0, MTIME_A, 64'd0, 8'h00, 0);
    checkOutput("mtime_after_10", clint_rdata, 64'd10);
    checkOutput("idle_mtip", 64'(mtip), 64'd0);

    // Compare at 20: interrupt rises and holds, then is retired and stays retired.
    applyStimulus(1, 1, CMP_A, 64'd20, 8'hFF, 0);
    while (m_mtime < 64'd25) applyStimulus(0, 0, 64'd0, 64'd0, 8'h00, 0);
    checkOutput("irq_at_20", 64'(clock_interr), 64'd1);
    applyStimulus(0, 0, 64'd0, 64'd0, 8'h00, 1);
    checkOutput("irq_retired", 64'(clock_interr), 64'd0);
    for (int i = 0; i < 100; i++) applyStimulus(0, 0, 64'd0, 64'd0, 8'h00, 0);
    checkOutput("no_retrigger_irq", 64'(clock_interr), 64'd0);
    checkOutput("no_retrigger_mtip", 64'(mtip), 64'd1);

    // Re-arm with compare at 200.
    applyStimulus(1, 1, CMP_A, 64'd200, 8'hFF, 0);
    checkOutput("rearm_mtip", 64'(mtip), 64'd0);
    while (m_mtime < 64'd205) applyStimulus(0, 0, 64'd0, 64'd0, 8'h00, 0);
    checkOutput("irq_at_200", 64'(clock_interr), 64'd1);

    // Compare write while pending keeps the request even though mtip falls.
    applyStimulus(1, 1, CMP_A, ALL_ONES, 8'hFF, 0);
    checkOutput("pend_hold_irq", 64'(clock_interr), 64'd1);
    checkOutput("pend_hold_mtip", 64'(mtip), 64'd0);

    // Compare write together with isdone: write wins, request returns next cycle.
    applyStimulus(1, 1, CMP_A, 64'd0, 8'hFF, 1);
    checkOutput("simul_idle", 64'(clock_interr), 64'd0);
    applyStimulus(0, 0, 64'd0, 64'd0, 8'h00, 0);
    checkOutput("simul_rearmed", 64'(clock_interr), 64'd1);

    // Wrap-around near the top of mtime.
    applyStimulus(0, 0, 64'd0, 64'd0, 8'h00, 1);
    applyStimulus(1, 1, CMP_A, ALL_ONES, 8'hFF, 0);
    applyStimulus(1, 1, MTIME_A, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 0);
    checkOutput("wrap_fe_mtip", 64'(mtip), 64'd0);
    applyStimulus(0, 0, 64'd0, 64'd0, 8'h00, 0);
    checkOutput("wrap_ff_mtip", 64'(mtip), 64'd1);
    applyStimulus(0, 0, 64'd0, 64'd0, 8'h00, 0);
    checkOutput("wrap_0_mtip", 64'(mtip), 64'd0);
    checkOutput("wrap_irq", 64'(clock_interr), 64'd1);
    applyStimulus(1, 0, MTIME_A, 64'd0, 8'h00, 0);
    checkOutput("wrap_mtime", clint_rdata, 64'd0);

    // Partial-strobe write in a tick cycle suppresses the increment.
    applyStimulus(0, 0, 64'd0, 64'd0, 8'h00, 1);
    applyStimulus(1, 1, MTIME_A, 64'h1122_3344_5566_7788, 8'hFF, 0);
    applyStimulus(1, 1, MTIME_A, 64'hAAAA_AAAA_0000_0000, 8'h0F, 0);
    applyStimulus(1, 0, MTIME_A | 64'd5, 64'd0, 8'h00, 0);
    checkOutput("partial_write", clint_rdata, 64'h1122_3344_0000_0000);

    // Random traffic with occasional mid-operation reset.
    for (int i = 0; i < 400; i++) begin
      pick = int'($urandom_range(0, 3));
      case (pick)
        0:       rnd_addr = MTIME_A;
        1:       rnd_addr = CMP_A;
        2:       rnd_addr = MTIME_A | 64'($urandom_range(0, 7));
        default: rnd_addr = {32'($urandom), 32'($urandom)} ^ 64'h0010_0000;
      endcase
      rnd_ce    = ($urandom_range(0, 1) == 1);
      rnd_we    = ($urandom_range(0, 2) == 0);
      rnd_done  = ($urandom_range(0, 9) == 0);
      cpu_rst_n = ($urandom_range(0, 99) != 0);
      applyStimulus(rnd_ce, rnd_we, rnd_addr, {32'($urandom), 32'($urandom)},
                    8'($urandom), rnd_done);
    end
    cpu_rst_n = 1'b1;

    // Divided tick: mtime advances once every four clocks.
    rst_n_4 = 1'b0;
    applyStimulus(0, 0, 64'd0, 64'd0, 8'h00, 0);
    rst_n_4 = 1'b1;
    for (int i = 0; i < 100; i++) applyStimulus(0, 0, 64'd0, 64'd0, 8'h00, 0);
    checkOutput("div4_count", 64'(e4), 64'd100);
    ce_4 = 1'b1; we_4 = 1'b0; addr_4 = MTIME_A;
    applyStimulus(0, 0, 64'd0, 64'd0, 8'h00, 0);
    checkOutput("div4_rvalid", 64'(rvalid_4), 64'd1);
    checkOutput("div4_mtime_100", rdata_4, 64'd25);

    // Non-matching accesses: no rvalid, no state change.
    ce_4 = 1'b1; we_4 = 1'b1; addr_4 = MTIME_A ^ 64'h1000; wdata_4 = 64'd0; wstrb_4 = 8'hFF;
    #1;
    checkOutput("div4_nohit", 64'(hit_4), 64'd0);
    applyStimulus(0, 0, 64'd0, 64'd0, 8'h00, 0);
    ce_4 = 1'b1; we_4 = 1'b0; addr_4 = CMP_A ^ 64'h8;
    applyStimulus(0, 0, 64'd0, 64'd0, 8'h00, 0);
    checkOutput("div4_nohit_rvalid", 64'(rvalid_4), 64'd0);
    checkOutput("div4_nohit_rdata", rdata_4, 64'd25);
    exp4 = 64'(e4 / 4);
    ce_4 = 1'b1; we_4 = 1'b0; addr_4 = MTIME_A;
    applyStimulus(0, 0, 64'd0, 64'd0, 8'h00, 0);
    checkOutput("div4_mtime_kept", rdata_4, exp4);
    ce_4 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
